rlight_sequencer: RTL
=====================

Name: rlight_sequencer

Overview:
Controller that sequences the running-light LED datapath. It holds a pattern, step timing and mode configuration written through a simple register port, and advances the LED pattern once per prescaled period. Modes are rotate and ping-pong. The block sits behind the TL-UL register adapter of the student rlight peripheral and drives the board LEDs directly.

Parameters:
- LED_W, 8, number of LEDs / pattern bits.
- CNT_W, 32, prescaler counter and register width.
- PRESCALE_RST, 24999999, reset value of PRESCALE (0.5 s per step at 50 MHz).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cfg_we_i  in  1  register write strobe; single-cycle write.
- cfg_addr_i  in  2  word index: 0 PATTERN, 1 PRESCALE, 2 CTRL, 3 STATUS.
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  read data, combinational from cfg_addr_i.
- led_o  out  LED_W  current pattern, registered.
- step_o  out  1  one-cycle pulse on every pattern step.

Behaviour:
- Reset values:
  - led_o = 1 (LSB only); step_o = 0.
  - PRESCALE = PRESCALE_RST; counter = 0.
  - CTRL: enable = 1, dir = 0 (left), mode = 0 (rotate).
  - Effective direction = 0; step count = 0.
- Register map (read data zero-extended; unused bits read 0):
  - PATTERN: [LED_W-1:0], reads back the current led_o.
  - PRESCALE: [CNT_W-1:0].
  - CTRL: bit0 enable, bit1 dir (0 = toward MSB, 1 = toward LSB), bit2 mode (0 rotate, 1 ping-pong).
  - STATUS: read-only; writes ignored. bit0 running (= enable), bit1 effective direction, [15:8] step count (mod 256).
- State machine:
  - IDLE: enable = 0; counter held at 0; no steps.
  - RUN: enable = 1. On CTRL write with enable 0->1, go to RUN with counter cleared. On enable 1->0, go to IDLE with counter cleared.
- Timing in RUN:
  - counter increments every cycle.
  - When counter == PRESCALE: counter -> 0, pattern steps, step_o = 1 in the following cycle together with the new led_o.
  - PRESCALE = 0 steps every cycle. Step period = PRESCALE + 1 cycles.
- Rotate mode: rotate by 1 in the effective direction; the end bit wraps around.
- Ping-pong mode: logical shift by 1 in the effective direction. Before shifting, check the end bit:
  - Toward MSB with led[LED_W-1] = 1: flip effective direction and shift toward LSB instead.
  - Toward LSB with led[0] = 1: symmetric.
  - Both end bits set: pattern held, direction unchanged, step_o still pulses.
  - All-zero pattern: stays zero, no flip.
- Effective direction:
  - Loaded from CTRL.dir on any CTRL write.
  - Rotate mode ignores flips and uses CTRL.dir.
- Step count increments on every step_o and wraps 255 -> 0.
- Writes:
  - PATTERN write loads led_o next cycle and clears the counter.
  - PRESCALE write clears the counter.
  - Write coinciding with a step: the write wins. On a PATTERN write no step occurs that cycle and no step_o pulse.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the first step comes PRESCALE_RST + 1 cycles after release.

Test Plan:
- Reset, PRESCALE = 3, no other writes -> led_o 0x01, 0x02, 0x04 at 4-cycle intervals; step_o pulses align with each change; STATUS[15:8] counts 1, 2, 3.
- PATTERN = 0x81, CTRL = 0x1 (rotate left), PRESCALE = 0 -> led_o 0x03, 0x06, 0x0C on consecutive cycles; CTRL = 0x3 from 0x81 -> 0xC0.
- Ping-pong: PATTERN = 0x40, CTRL = 0x5, PRESCALE = 0 -> 0x80, then 0x40 with STATUS bit1 = 1; continues to 0x01, then 0x02 with bit1 = 0; PATTERN = 0x81 -> held at 0x81, step_o still pulses.
- CTRL = 0x0 mid-run -> led_o frozen, no step_o for 20 cycles; CTRL = 0x1 -> first step exactly PRESCALE + 1 cycles later.
- PATTERN write in the same cycle the counter hits PRESCALE -> led_o = written value, no step_o that cycle, next step PRESCALE + 1 cycles later; STATUS write ignored; reset pulse mid-run -> led_o = 0x01, PRESCALE reads 24999999.
- Step-count wrap: PRESCALE = 0, run 256 steps -> STATUS[15:8] returns to 0x00.

Source files
------------

// File: rtl/rlight_sequencer.sv
// rlight_sequencer: running-light LED sequencer.
//
// Holds the LED pattern, the step prescaler and the mode configuration, all written through a
// single-cycle register port. While enabled, the pattern advances once every PRESCALE + 1
// cycles, either rotating or bouncing between the ends (ping-pong).
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   cfg_we_i     register write strobe (single cycle)
//   cfg_addr_i   word index: 0 PATTERN, 1 PRESCALE, 2 CTRL, 3 STATUS (read-only)
//   cfg_wdata_i  write data
//   cfg_rdata_o  read data, combinational from cfg_addr_i, zero-extended
//   led_o        current pattern (registered)
//   step_o       one-cycle pulse alongside every pattern change caused by a step
module rlight_sequencer #(
    parameter int unsigned LED_W        = 8,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PRESCALE_RST = 24999999
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [31:0]      cfg_wdata_i,
    output logic [31:0]      cfg_rdata_o,
    output logic [LED_W-1:0] led_o,
    output logic             step_o
);

    localparam logic [1:0] AddrPattern  = 2'd0;
    localparam logic [1:0] AddrPrescale = 2'd1;
    localparam logic [1:0] AddrCtrl     = 2'd2;
    localparam logic [1:0] AddrStatus   = 2'd3;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [LED_W-1:0] led_q;
    logic [CNT_W-1:0] prescale_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;       // CTRL.dir as written
    logic             mode_q;      // 0 rotate, 1 ping-pong
    logic             eff_dir_q;   // direction actually used; ping-pong may flip it
    logic             step_q;
    logic [7:0]       step_cnt_q;

    logic wr_pattern, wr_prescale, wr_ctrl, wr_any;
    logic cnt_hit, do_step;

    assign wr_pattern  = cfg_we_i && (cfg_addr_i == AddrPattern);
    assign wr_prescale = cfg_we_i && (cfg_addr_i == AddrPrescale);
    assign wr_ctrl     = cfg_we_i && (cfg_addr_i == AddrCtrl);
    // STATUS writes are ignored entirely and do not disturb stepping.
    assign wr_any      = wr_pattern || wr_prescale || wr_ctrl;

    assign cnt_hit = (cnt_q == prescale_q);
    // A register write in the same cycle takes priority over the step.
    assign do_step = (state_q == StRun) && cnt_hit && !wr_any;

    // Next pattern and direction if a step happens this cycle.
    logic [LED_W-1:0] led_next;
    logic             eff_dir_next;

    always_comb begin
        led_next     = led_q;
        eff_dir_next = eff_dir_q;
        if (!mode_q) begin
            // Rotate: direction always follows CTRL.dir.
            if (dir_q) begin
                led_next = {led_q[0], led_q[LED_W-1:1]};
            end else begin
                led_next = {led_q[LED_W-2:0], led_q[LED_W-1]};
            end
        end else if ((led_q == '0) || (led_q[LED_W-1] && led_q[0])) begin
            // Nothing can move (empty, or both ends occupied): hold pattern and direction.
            led_next = led_q;
        end else if (!eff_dir_q) begin
            if (led_q[LED_W-1]) begin
                eff_dir_next = 1'b1;
                led_next     = led_q >> 1;
            end else begin
                led_next = led_q << 1;
            end
        end else begin
            if (led_q[0]) begin
                eff_dir_next = 1'b0;
                led_next     = led_q << 1;
            end else begin
                led_next = led_q >> 1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StRun;
            led_q      <= LED_W'(1);
            prescale_q <= CNT_W'(PRESCALE_RST);
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            mode_q     <= 1'b0;
            eff_dir_q  <= 1'b0;
            step_q     <= 1'b0;
            step_cnt_q <= 8'd0;
        end else begin
            step_q <= do_step;

            if (wr_pattern) begin
                led_q <= cfg_wdata_i[LED_W-1:0];
            end else if (do_step) begin
                led_q <= led_next;
            end

            if (wr_prescale) begin
                prescale_q <= cfg_wdata_i[CNT_W-1:0];
            end

            if (wr_ctrl) begin
                state_q   <= cfg_wdata_i[0] ? StRun : StIdle;
                dir_q     <= cfg_wdata_i[1];
                mode_q    <= cfg_wdata_i[2];
                eff_dir_q <= cfg_wdata_i[1];
            end else if (do_step) begin
                eff_dir_q <= eff_dir_next;
            end

            if (do_step) begin
                step_cnt_q <= step_cnt_q + 8'd1;
            end

            // Every configuration write restarts the step period.
            if (wr_any || (state_q == StIdle) || cnt_hit) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        unique case (cfg_addr_i)
            AddrPattern:  cfg_rdata_o[LED_W-1:0] = led_q;
            AddrPrescale: cfg_rdata_o[CNT_W-1:0] = prescale_q;
            AddrCtrl:     cfg_rdata_o[2:0] = {mode_q, dir_q, state_q == StRun};
            AddrStatus: begin
                cfg_rdata_o[0]    = (state_q == StRun);
                cfg_rdata_o[1]    = eff_dir_q;
                cfg_rdata_o[15:8] = step_cnt_q;
            end
            default:      cfg_rdata_o = '0;
        endcase
    end

    assign led_o  = led_q;
    assign step_o = step_q;

    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata_i;

endmodule
